// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU stage between decode/register-file read and writeback.
// It accepts one operation per valid/ready handshake and returns a registered
// result through a second handshake. It provides saturating ADD/SUB, a
// two-cycle signed byte reduction (RED), lane-wise saturating add (PADDSB) and
// an internal {N,V,Z} flag register that branch logic reads.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid / in_ready  operation handshake (opcode, a, b, imm sampled on accept)
//   opcode               ISA opcode (ADD=0 ... HLT=F)
//   a, b                 operands
//   imm                  zero-extended immediate (shift amount in imm[SHW-1:0])
//   out_valid / out_ready result handshake
//   alu_out              registered result
//   flags_out            {N,V,Z} flag register
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH),
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [2:0]       flags_out
);

  localparam int NB = WIDTH / 8;
  localparam int NL = WIDTH / LANE;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_RED    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_PCS    = 4'hE;

  typedef enum logic [1:0] {IDLE, RED1, OUT} state_t;
  state_t state;

  logic             accept;
  logic [WIDTH-1:0] sum, diff, res, red_sum;
  logic [SHW-1:0]   sh;
  logic             ovf, upd_nv, upd_z;
  logic [LANE-1:0]  la, lb, ls;
  logic [8:0]       psum_q [NB];

  assign in_ready = (state == IDLE) || (state == OUT && out_ready);
  assign accept   = in_valid && in_ready;
  assign sh       = imm[SHW-1:0];

  always_comb begin
    sum    = a + b;
    diff   = a - b;
    res    = '0;
    ovf    = 1'b0;
    upd_nv = 1'b0;
    upd_z  = 1'b0;
    la     = '0;
    lb     = '0;
    ls     = '0;
    case (opcode)
      OP_ADD: begin
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        // Saturate toward the sign of a: 0x7F..F if a >= 0, else 0x80..0.
        res    = ovf ? {a[WIDTH-1], {(WIDTH-1){~a[WIDTH-1]}}} : sum;
        upd_nv = 1'b1;
        upd_z  = 1'b1;
      end
      OP_SUB: begin
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        res    = ovf ? {a[WIDTH-1], {(WIDTH-1){~a[WIDTH-1]}}} : diff;
        upd_nv = 1'b1;
        upd_z  = 1'b1;
      end
      OP_XOR: begin
        res   = a ^ b;
        upd_z = 1'b1;
      end
      OP_SLL: begin
        res   = a << sh;
        upd_z = 1'b1;
      end
      OP_SRA: begin
        res   = $signed(a) >>> sh;
        upd_z = 1'b1;
      end
      OP_ROR: begin
        // Rotate by shifting a doubled copy and keeping the low half.
        res   = WIDTH'({a, a} >> sh);
        upd_z = 1'b1;
      end
      OP_PADDSB: begin
        for (int unsigned i = 0; i < NL; i++) begin
          la = a[i*LANE +: LANE];
          lb = b[i*LANE +: LANE];
          ls = la + lb;
          if ((la[LANE-1] == lb[LANE-1]) && (ls[LANE-1] != la[LANE-1]))
            res[i*LANE +: LANE] = {la[LANE-1], {(LANE-1){~la[LANE-1]}}};
          else
            res[i*LANE +: LANE] = ls;
        end
      end
      OP_LW, OP_SW: res = {a[WIDTH-1:1], 1'b0} + (imm << 1);
      OP_LHB:       res[15:0] = {imm[7:0], a[7:0]};
      OP_LLB:       res = {a[WIDTH-1:8], imm[7:0]};
      OP_PCS:       res = sum;
      default:      res = '0;
    endcase
  end

  // Second RED cycle: add the registered 9-bit byte-pair sums, sign-extended.
  always_comb begin
    red_sum = '0;
    for (int unsigned i = 0; i < NB; i++)
      red_sum = red_sum + {{(WIDTH-9){psum_q[i][8]}}, psum_q[i]};
  end

  always_ff @(posedge clk) begin
    if (accept && opcode == OP_RED) begin
      for (int unsigned i = 0; i < NB; i++)
        psum_q[i] <= {a[i*8+7], a[i*8 +: 8]} + {b[i*8+7], b[i*8 +: 8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      alu_out   <= '0;
      flags_out <= 3'b000;
    end else begin
      case (state)
        RED1: begin
          alu_out   <= red_sum;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        IDLE, OUT: begin
          if (accept) begin
            if (opcode == OP_RED) begin
              out_valid <= 1'b0;
              state     <= RED1;
            end else begin
              alu_out   <= res;
              out_valid <= 1'b1;
              state     <= OUT;
              if (upd_nv) begin
                flags_out[2] <= res[WIDTH-1];
                flags_out[1] <= ovf;
              end
              if (upd_z)
                flags_out[0] <= (res == '0);
            end
          end else if (state == OUT && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe. A 16-bit instance runs a
// vector table through a result scoreboard plus hand-written RED, backpressure
// and reset-abort sequences; a 32-bit instance covers ADD saturation and RED.
module tb_alu_pipe;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, RED = 4'h2, XOR = 4'h3,
                         SLL = 4'h4, SRA = 4'h5, ROR = 4'h6, PADDSB = 4'h7,
                         LW = 4'h8, SW = 4'h9, LHB = 4'hA, LLB = 4'hB,
                         BR = 4'hD, PCS = 4'hE, HLT = 4'hF;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  opcode;
  logic [15:0] a, b, imm, alu_out;
  logic [2:0]  flags_out;

  logic        rst32, in_valid32, in_ready32, out_valid32, out_ready32;
  logic [3:0]  opcode32;
  logic [31:0] a32, b32, imm32, alu_out32;
  logic [2:0]  flags_out32;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out), .flags_out(flags_out)
  );

  alu_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst32), .in_valid(in_valid32), .in_ready(in_ready32),
    .opcode(opcode32), .a(a32), .b(b32), .imm(imm32), .out_valid(out_valid32),
    .out_ready(out_ready32), .alu_out(alu_out32), .flags_out(flags_out32)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b, imm, res;
    logic [2:0]  flags;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  flags;
    string       name;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[23];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: a result is compared on the cycle it is handed off.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: result 0x%0h with nothing expected", alu_out);
      end else begin
        e = sb.pop_front();
        check({e.name, "_res"}, alu_out, e.res);
        check({e.name, "_flags"}, flags_out, e.flags);
      end
    end
  end

  // Called #1 after a clock edge; returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] iimm, input logic [15:0] eres,
                       input logic [2:0] efl, input string name);
    int unsigned waited = 0;
    opcode = op; a = ia; b = ib; imm = iimm; in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: in_ready never rose, got 0 expected 1", name);
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{eres, efl, name});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opcode = '0; a = '0; b = '0; imm = '0;
    rst32 = 1'b1; in_valid32 = 1'b0; out_ready32 = 1'b1; opcode32 = '0;
    a32 = '0; b32 = '0; imm32 = '0;

    vecs[0]  = '{ADD,    16'h7000, 16'h2000, 16'h0000, 16'h7FFF, 3'b010};
    vecs[1]  = '{SUB,    16'h0005, 16'h0005, 16'h0000, 16'h0000, 3'b001};
    vecs[2]  = '{ADD,    16'h7000, 16'h2000, 16'h0000, 16'h7FFF, 3'b010};
    vecs[3]  = '{XOR,    16'h1234, 16'h1234, 16'h0000, 16'h0000, 3'b011};
    vecs[4]  = '{LLB,    16'h1234, 16'h0000, 16'h00AB, 16'h12AB, 3'b011};
    vecs[5]  = '{RED,    16'h7F80, 16'h0101, 16'h0000, 16'h0001, 3'b011};
    vecs[6]  = '{RED,    16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFC, 3'b011};
    vecs[7]  = '{PADDSB, 16'h7777, 16'h1111, 16'h0000, 16'h7777, 3'b011};
    vecs[8]  = '{SLL,    16'h8001, 16'h0000, 16'h0001, 16'h0002, 3'b010};
    vecs[9]  = '{SRA,    16'h8001, 16'h0000, 16'h0001, 16'hC000, 3'b010};
    vecs[10] = '{ROR,    16'h8001, 16'h0000, 16'h0001, 16'hC000, 3'b010};
    vecs[11] = '{SUB,    16'h8000, 16'h0001, 16'h0000, 16'h8000, 3'b110};
    vecs[12] = '{ADD,    16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 3'b001};
    vecs[13] = '{SLL,    16'h1234, 16'h0000, 16'h0000, 16'h1234, 3'b000};
    vecs[14] = '{LHB,    16'h1234, 16'h0000, 16'h00CD, 16'hCD34, 3'b000};
    vecs[15] = '{LW,     16'h1235, 16'h0000, 16'h0004, 16'h123C, 3'b000};
    vecs[16] = '{SW,     16'hFFFF, 16'h0000, 16'h0002, 16'h0002, 3'b000};
    vecs[17] = '{PCS,    16'h7000, 16'h2000, 16'h0000, 16'h9000, 3'b000};
    vecs[18] = '{HLT,    16'h1234, 16'h5678, 16'h0000, 16'h0000, 3'b000};
    vecs[19] = '{PADDSB, 16'h8888, 16'hF0F1, 16'h0000, 16'h8889, 3'b000};
    vecs[20] = '{SRA,    16'h4000, 16'h0000, 16'h000F, 16'h0000, 3'b001};
    vecs[21] = '{ROR,    16'h1234, 16'h0000, 16'h0014, 16'h4123, 3'b000};
    vecs[22] = '{BR,     16'h1234, 16'h1111, 16'h0000, 16'h0000, 3'b000};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; rst32 = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_out", alu_out, 0);
    check("rst_flags", flags_out, 0);
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 23; i++)
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].res, vecs[i].flags,
            $sformatf("vec%0d", i));

    // RED occupies two cycles with in_ready low in between.
    issue(RED, 16'h0102, 16'h03FF, 16'h0000, 16'h0005, 3'b000, "red_seq");
    check("red1_in_ready", in_ready, 0);
    check("red1_out_valid", out_valid, 0);
    @(posedge clk); #1;
    check("red_out_valid", out_valid, 1);
    check("red_alu_out", alu_out, 16'h0005);
    check("red_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Backpressure: result held, next op waits, then issues on the retire edge.
    out_ready = 1'b0;
    issue(ADD, 16'h0001, 16'h0002, 16'h0000, 16'h0003, 3'b000, "bp_add");
    opcode = XOR; a = 16'h00FF; b = 16'h0F0F; imm = '0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_in_ready%0d", k), in_ready, 0);
      check($sformatf("bp_alu_out%0d", k), alu_out, 16'h0003);
      check($sformatf("bp_out_valid%0d", k), out_valid, 1);
      @(posedge clk); #1;
    end
    sb.push_back('{16'h0FF0, 3'b000, "bp_xor"});
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_same_edge_valid", out_valid, 1);
    check("bp_same_edge_out", alu_out, 16'h0FF0);
    @(posedge clk); #1;

    // Reset during RED1 aborts with no result and clears flags.
    issue(ADD, 16'h7000, 16'h2000, 16'h0000, 16'h7FFF, 3'b010, "pre_abort_add");
    opcode = RED; a = 16'h0101; b = 16'h0101; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_red1_in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_flags", flags_out, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_alu_out", alu_out, 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_result", out_valid, 0);

    // 32-bit instance.
    opcode32 = ADD; a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    check("w32_add_valid", out_valid32, 1);
    check("w32_add_out", alu_out32, 32'h7FFF_FFFF);
    check("w32_add_flags", flags_out32, 3'b010);
    opcode32 = RED; a32 = 32'h8080_8080; b32 = 32'h8080_8080; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    check("w32_red1_in_ready", in_ready32, 0);
    @(posedge clk); #1;
    check("w32_red_valid", out_valid32, 1);
    check("w32_red_out", alu_out32, 32'hFFFF_FC00);
    check("w32_red_flags", flags_out32, 3'b010);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
